// File: rtl/storage_req_arbiter_pkg.sv
// Shared types and constants for the storage request arbiter.
package storage_pkg;

  localparam int          MEM_DW          = 32;
  localparam logic [31:0] SRAM_LIMIT_ADDR = 32'h0000_0FFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    DRAIN    = 2'd2,
    RESP_ERR = 2'd3
  } arb_state_e;

  // One storage-controller request; used both for the latched copy and the mem_* bundle.
  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [MEM_DW-1:0]     wdata;
    logic [MEM_DW/8-1:0]   be;
  } mem_req_t;

  // Addresses at or above the SRAM limit are backed by SPI flash.
  function automatic logic is_flash(input logic [31:0] addr, input logic [31:0] limit);
    return (addr >= limit);
  endfunction

endpackage

// File: rtl/storage_req_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester after ptr.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  // Scan from the slot after the last winner, wrapping, and take the first requester.
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/storage_req_arbiter.sv
// Shares one storage controller port between N_REQ requesters: round-robin grant,
// single access in flight, flash-write rejection and access timeout.
module storage_req_arbiter
  import storage_pkg::*;
#(
  parameter int          N_REQ       = 3,
  parameter int          MEM_W       = MEM_DW,
  parameter logic [31:0] SRAM_LIMIT  = SRAM_LIMIT_ADDR,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ-1:0][31:0]        req_addr,
  input  logic [N_REQ-1:0][MEM_W-1:0]   req_wdata,
  input  logic [N_REQ-1:0][MEM_W/8-1:0] req_be,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [MEM_W-1:0]              rsp_rdata,
  output logic                          rsp_err,
  input  logic                          prog_mode,
  output logic                          idle,
  output logic                          timeout_seen,
  output logic                          mem_access,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [MEM_W-1:0]              mem_wdata,
  output logic [MEM_W/8-1:0]            mem_be,
  input  logic [MEM_W-1:0]              mem_rdata,
  input  logic                          mem_valid
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;      // last winner; also owner of the transaction in flight
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              tseen_q, tseen_d;
  mem_req_t          req_q, req_d;
  logic [MEM_W-1:0]  rdata_q, rdata_d;

  logic [N_REQ-1:0]  gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              grant_en;
  logic              in_access;
  logic              in_resp;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // Encode the one-hot grant and decide whether a grant may be issued this cycle.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
    grant_en = (state_q == IDLE) && !prog_mode && (|req_valid);
  end

  // Next-state logic: grant, access with timeout, one drain cycle, reject path.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tseen_d = tseen_q;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          ptr_d = gnt_idx;
          err_d = 1'b0;
          cnt_d = '0;
          if (req_we[gnt_idx] && is_flash(req_addr[gnt_idx], SRAM_LIMIT)) state_d = RESP_ERR;
          else                                                             state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion arriving on the timeout cycle still counts as success.
        if (mem_valid) begin
          state_d = DRAIN;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          tseen_d = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      RESP_ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath capture: latch the granted request and the returned read data.
  always_comb begin
    req_d   = req_q;
    rdata_d = rdata_q;
    if (grant_en) begin
      req_d.we    = req_we[gnt_idx];
      req_d.addr  = req_addr[gnt_idx];
      req_d.wdata = req_wdata[gnt_idx];
      req_d.be    = req_be[gnt_idx];
    end
    if ((state_q == ACCESS) && mem_valid) rdata_d = mem_rdata;
  end

  // Control state register with synchronous active-low reset; an in-flight access is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tseen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tseen_q <= tseen_d;
    end
  end

  // Data registers carry no reset; every output they feed is gated by the state.
  always_ff @(posedge clk) begin
    req_q   <= req_d;
    rdata_q <= rdata_d;
  end

  // Output decode: mem_* only from latched registers in ACCESS, responses to the owner.
  always_comb begin
    in_access    = (state_q == ACCESS);
    in_resp      = (state_q == DRAIN) || (state_q == RESP_ERR);
    req_ready    = grant_en ? gnt : '0;
    mem_access   = in_access;
    mem_we       = in_access & req_q.we;
    mem_addr     = in_access ? req_q.addr  : '0;
    mem_wdata    = in_access ? req_q.wdata : '0;
    mem_be       = in_access ? req_q.be    : '0;
    rsp_valid    = in_resp ? (N_REQ'(1) << ptr_q) : '0;
    rsp_err      = (state_q == RESP_ERR) || ((state_q == DRAIN) && err_q);
    rsp_rdata    = ((state_q == DRAIN) && !err_q) ? rdata_q : '0;
    idle         = (state_q == IDLE);
    timeout_seen = tseen_q;
  end

endmodule

// File: tb/tb_storage_req_arbiter.sv
// Bench for storage_req_arbiter: transaction-schedule reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_storage_req_arbiter;

  localparam int          N   = 3;
  localparam int          MW  = 32;
  localparam int          TO  = 16;
  localparam logic [31:0] LIM = 32'h0000_0FFF;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N-1:0]             req_valid, req_ready, req_we, rsp_valid;
  logic [N-1:0][31:0]       req_addr;
  logic [N-1:0][MW-1:0]     req_wdata;
  logic [N-1:0][MW/8-1:0]   req_be;
  logic [MW-1:0]            rsp_rdata, mem_rdata, mem_wdata;
  logic                     rsp_err, prog_mode, idle, timeout_seen;
  logic                     mem_access, mem_we, mem_valid;
  logic [31:0]              mem_addr;
  logic [MW/8-1:0]          mem_be;

  storage_req_arbiter #(
    .N_REQ(N), .MEM_W(MW), .SRAM_LIMIT(LIM), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .prog_mode(prog_mode), .idle(idle), .timeout_seen(timeout_seen),
    .mem_access(mem_access), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mcyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, mcyc);
    end
  endtask

  // ---------------- memory controller stand-in ----------------
  bit          rand_mode = 0;
  bit          use_fixed = 1;
  logic [31:0] fixed_data = 32'hDEADBEEF;
  int          mem_delay  = 1;   // mem_valid on access cycle (delay+1); negative = never
  int          cur_delay  = 1;
  int          acc_cnt    = 0;

  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_access === 1'b1) acc_cnt++; else acc_cnt = 0;
      if (acc_cnt == 1) begin
        if (rand_mode) begin
          case ($urandom_range(0, 7))
            0:       cur_delay = -1;
            1:       cur_delay = TO - 1;
            default: cur_delay = $urandom_range(0, 5);
          endcase
        end else begin
          cur_delay = mem_delay;
        end
      end
      if (mem_access === 1'b1) mem_valid = (cur_delay >= 0) && (acc_cnt == cur_delay + 1);
      else                     mem_valid = rand_mode && ($urandom_range(0, 9) == 0);
      mem_rdata = use_fixed ? fixed_data : $urandom;
    end
  end

  // ---------------- reference model + monitor ----------------
  int          m_last = 0, m_owner = 0, m_acc_start = -1, m_resp_cyc = -1;
  bit          m_err = 0, m_tseen = 0;
  logic [31:0] m_rdata = '0;
  logic        m_we = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = '0;

  int          grant_q[$];
  int          last_acc_cyc = 0, last_rsp_cyc = 0, rsp_count = 0, acc_cycles = 0;
  bit          last_rsp_err = 0, mem_acc_seen = 0;
  logic [31:0] last_rsp_data = '0;
  logic [N-1:0] last_rsp_vec = '0, rdy_seen = '0;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  initial begin
    bit in_acc, resp_now, m_idle;
    int g;
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      in_acc   = (m_acc_start >= 0) && (m_resp_cyc < 0);
      resp_now = (m_resp_cyc == mcyc);
      m_idle   = !in_acc && !resp_now;
      g        = (m_idle && !prog_mode) ? rr_pick(req_valid, m_last) : -1;

      chk("req_ready",    req_ready,    (g >= 0) ? (64'd1 << g) : 64'd0);
      chk("idle",         idle,         m_idle);
      chk("mem_access",   mem_access,   in_acc);
      chk("mem_we",       mem_we,       in_acc ? m_we : 1'b0);
      chk("mem_addr",     mem_addr,     in_acc ? m_addr : 32'd0);
      chk("mem_wdata",    mem_wdata,    in_acc ? m_wdata : 32'd0);
      chk("mem_be",       mem_be,       in_acc ? m_be : 4'd0);
      chk("rsp_valid",    rsp_valid,    resp_now ? (64'd1 << m_owner) : 64'd0);
      chk("rsp_err",      rsp_err,      resp_now && m_err);
      chk("rsp_rdata",    rsp_rdata,    resp_now ? m_rdata : 32'd0);
      chk("timeout_seen", timeout_seen, m_tseen);

      // monitor records for the directed scenarios
      rdy_seen = req_ready;
      if (|req_ready) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) grant_q.push_back(i);
        last_acc_cyc = mcyc;
        acc_cycles   = 0;
      end
      if (mem_access === 1'b1) begin
        mem_acc_seen = 1;
        acc_cycles++;
      end
      if (|rsp_valid) begin
        rsp_count++;
        last_rsp_cyc  = mcyc;
        last_rsp_err  = rsp_err;
        last_rsp_data = rsp_rdata;
        last_rsp_vec  = rsp_valid;
      end

      // advance the model by one clock edge
      if (rst === 1'b0) begin
        m_last = 0; m_acc_start = -1; m_resp_cyc = -1; m_tseen = 0; m_err = 0;
      end else if (resp_now) begin
        m_resp_cyc  = -1;
        m_acc_start = -1;
      end else if (in_acc) begin
        if (mem_valid === 1'b1) begin
          m_resp_cyc = mcyc + 1; m_err = 0; m_rdata = mem_rdata;
        end else if (mcyc - m_acc_start == TO - 1) begin
          m_resp_cyc = mcyc + 1; m_err = 1; m_rdata = '0; m_tseen = 1;
        end
      end else if (g >= 0) begin
        m_last = g; m_owner = g;
        m_we = req_we[g]; m_addr = req_addr[g]; m_wdata = req_wdata[g]; m_be = req_be[g];
        if (m_we && (m_addr >= LIM)) begin
          m_resp_cyc = mcyc + 1; m_err = 1; m_rdata = '0;
        end else begin
          m_acc_start = mcyc + 1;
        end
      end
      mcyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int i, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    bit got = 0;
    req_we[i] = we; req_addr[i] = addr; req_wdata[i] = wd; req_be[i] = be; req_valid[i] = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk); #1;
      if (req_ready[i]) got = 1;
    end
    chk("accepted", got, 1'b1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int bound);
    int start = rsp_count;
    bit got = 0;
    for (int n = 0; n < bound && !got; n++) begin
      @(negedge clk); #1;
      if (rsp_count != start) got = 1;
    end
    chk("rsp_arrived", got, 1'b1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0FFE;
      1:       return 32'h0000_0FFF;
      2:       return 32'h0000_1000;
      3, 4:    return 32'($urandom_range(0, 32'hFFE));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int exp_ord[6] = '{1, 2, 0, 1, 2, 0};
    int start;
    rst = 1'b0; prog_mode = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;

    // reset state
    @(negedge clk); #1;
    chk("rst_idle", idle, 1'b1);
    chk("rst_mem_access", mem_access, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 3'b000);
    chk("rst_timeout_seen", timeout_seen, 1'b0);
    @(posedge clk); #1;

    // 1: single SRAM read, 3-cycle latency
    mem_delay = 1;
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF);
    wait_rsp(20);
    chk("t1_latency", last_rsp_cyc - last_acc_cyc, 3);
    chk("t1_rdata", last_rsp_data, 32'hDEADBEEF);
    chk("t1_err", last_rsp_err, 1'b0);
    chk("t1_owner", last_rsp_vec, 3'b001);

    // 2: three requesters contending, round-robin order
    grant_q.delete();
    req_addr[0] = 32'h10; req_addr[1] = 32'h20; req_addr[2] = 32'h30;
    req_we = '0; req_be = '1; req_valid = 3'b111;
    for (int n = 0; n < 100 && grant_q.size() < 6; n++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("t2_grant_count", grant_q.size(), 6);
    for (int k = 0; k < 6 && k < grant_q.size(); k++) chk("t2_grant_order", grant_q[k], exp_ord[k]);
    repeat (6) @(posedge clk); #1;

    // 3: write to flash rejected without touching the controller
    mem_acc_seen = 0;
    issue(2, 1'b1, 32'h0000_2000, 32'h55, 4'hF);
    wait_rsp(10);
    chk("t3_latency", last_rsp_cyc - last_acc_cyc, 1);
    chk("t3_err", last_rsp_err, 1'b1);
    chk("t3_owner", last_rsp_vec, 3'b100);
    chk("t3_rdata", last_rsp_data, 32'h0);
    chk("t3_no_mem_access", mem_acc_seen, 1'b0);
    // boundary: first flash address rejected, last SRAM address accepted
    issue(1, 1'b1, 32'h0000_0FFF, 32'h1, 4'h3);
    wait_rsp(10);
    chk("lim_write_err", last_rsp_err, 1'b1);
    issue(1, 1'b1, 32'h0000_0FFE, 32'h2, 4'hC);
    wait_rsp(20);
    chk("below_lim_write_err", last_rsp_err, 1'b0);
    chk("below_lim_latency", last_rsp_cyc - last_acc_cyc, 3);

    // 4: flash read times out, then an SRAM read succeeds
    mem_delay = -1;
    issue(1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    wait_rsp(40);
    chk("t4_latency", last_rsp_cyc - last_acc_cyc, 17);
    chk("t4_access_cycles", acc_cycles, 16);
    chk("t4_err", last_rsp_err, 1'b1);
    chk("t4_timeout_seen", timeout_seen, 1'b1);
    mem_delay = 1;
    issue(0, 1'b0, 32'h40, 32'h0, 4'hF);
    wait_rsp(20);
    chk("t4_after_err", last_rsp_err, 1'b0);
    chk("t4_after_rdata", last_rsp_data, 32'hDEADBEEF);

    // 5: prog_mode rises during a flash read; response still delivered, then no grants
    mem_delay = 12;
    fixed_data = 32'hCAFE_F00D;
    issue(0, 1'b0, 32'h9000_0000, 32'h0, 4'hF);
    prog_mode = 1'b1;
    req_we[1] = 1'b0; req_addr[1] = 32'h80; req_valid[1] = 1'b1;
    wait_rsp(40);
    chk("t5_latency", last_rsp_cyc - last_acc_cyc, 14);
    chk("t5_err", last_rsp_err, 1'b0);
    chk("t5_rdata", last_rsp_data, 32'hCAFE_F00D);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); #1;
      chk("t5_ready_blocked", req_ready, 3'b000);
    end
    @(posedge clk); #1;
    prog_mode = 1'b0;
    mem_delay = 1;
    issue(1, 1'b0, 32'h80, 32'h0, 4'hF);
    wait_rsp(20);
    chk("t5_resume_owner", last_rsp_vec, 3'b010);

    // 6: reset during ACCESS drops the transaction
    mem_delay = -1;
    issue(0, 1'b0, 32'h300, 32'h0, 4'hF);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    start = rsp_count;
    @(negedge clk); #1;
    chk("t6_mem_access", mem_access, 1'b0);
    chk("t6_idle", idle, 1'b1);
    chk("t6_rsp_valid", rsp_valid, 3'b000);
    chk("t6_timeout_cleared", timeout_seen, 1'b0);
    repeat (20) @(negedge clk);
    chk("t6_no_response", rsp_count - start, 0);
    @(posedge clk); #1;
    mem_delay = 1;
    fixed_data = 32'h1234_5678;
    issue(0, 1'b0, 32'h300, 32'h0, 4'hF);
    wait_rsp(20);
    chk("t6_retry_err", last_rsp_err, 1'b0);
    chk("t6_retry_rdata", last_rsp_data, 32'h1234_5678);
    chk("t6_retry_latency", last_rsp_cyc - last_acc_cyc, 3);

    // randomized traffic, checked cycle by cycle against the model
    rand_mode = 1; use_fixed = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || rdy_seen[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            req_we[i]    = $urandom_range(0, 1);
            req_addr[i]  = rand_addr();
            req_wdata[i] = $urandom;
            req_be[i]    = 4'($urandom_range(0, 15));
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      prog_mode = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 499) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0; prog_mode = 1'b0; rst = 1'b1;
    rand_mode = 0; mem_delay = 1;
    repeat (30) @(posedge clk);
    @(negedge clk); #1;
    chk("final_idle", idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
